// File: rtl/cache_pkg.sv
// Shared cache/memory definitions: block geometry, block address width and
// the backing-store FSM state encoding.
package cache_pkg;

    localparam int BLOCK_SIZE = 128;
    localparam int WORD_SIZE  = 32;
    localparam int ADDR_W     = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port block storage with a registered read port.
// Contents are not reset.
module mem_array
    import cache_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [BLOCK_SIZE-1:0] wdata,
    output logic [BLOCK_SIZE-1:0] rdata
);

    logic [BLOCK_SIZE-1:0] mem_q [DEPTH];
    logic [BLOCK_SIZE-1:0] rdata_q;

    // Read-before-write: a same-cycle read of the written entry sees the old block.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Block-granular backing store answering refills/write-backs after MEM_LATENCY
// cycles. Define MEM_STATS_EN to add saturating rd_count/wr_count outputs.
module main_memory
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY  = 4,
    parameter int DEPTH_BLOCKS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_mem,
    input  logic                  write_en_mem,
    input  logic [ADDR_W-1:0]     addr_mem,
    input  logic [BLOCK_SIZE-1:0] dirty_block_in,
    output logic [BLOCK_SIZE-1:0] data_out_mem,
    output logic                  ready_mem,
`ifdef MEM_STATS_EN
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
`endif
    output mem_state_e            state_dbg
);

    localparam int         IDX_W  = $clog2(DEPTH_BLOCKS);
    localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);

    mem_state_e            state_q;
    logic [7:0]            cnt_q;
    logic                  is_wr_q;
    logic [IDX_W-1:0]      idx_q;
    logic [BLOCK_SIZE-1:0] wdata_q;
    logic                  ready_q;
    logic [BLOCK_SIZE-1:0] dout_q;

    logic [IDX_W-1:0]      idx_d;
    logic                  we_d;
    logic [BLOCK_SIZE-1:0] rdata;
    logic                  unused_addr;

    assign unused_addr = ^addr_mem[ADDR_W-1:IDX_W];

    // In IDLE the array is addressed straight from the port so a latency-1
    // read has its block ready in the RESP cycle that follows acceptance.
    assign idx_d = (state_q == IDLE) ? addr_mem[IDX_W-1:0] : idx_q;
    assign we_d  = (state_q == RESP) && is_wr_q;

    mem_array #(
        .DEPTH (DEPTH_BLOCKS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we_d),
        .idx   (idx_d),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write wins when both enables are high.
                    if (write_en_mem || read_en_mem) begin
                        is_wr_q <= write_en_mem;
                        idx_q   <= addr_mem[IDX_W-1:0];
                        wdata_q <= dirty_block_in;
                        cnt_q   <= LAT_M1;
                        if (MEM_LATENCY == 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (!is_wr_q) begin
                        dout_q <= rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out_mem = (state_q == RESP && !is_wr_q) ? rdata : dout_q;
    assign ready_mem    = ready_q;
    assign state_dbg    = state_q;

`ifdef MEM_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else if (state_q == RESP) begin
            if (is_wr_q && wr_count_q != 32'hFFFF_FFFF) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (!is_wr_q && rd_count_q != 32'hFFFF_FFFF) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: latency-4 instance for the main sequence and
// a latency-1 instance for back-to-back traffic (and counters with MEM_STATS_EN).
module tb_main_memory;
  import cache_pkg::*;

  int vectors     = 0;
  int miscompares = 0;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  read_en, write_en, ready;
  logic [ADDR_W-1:0]     addr;
  logic [BLOCK_SIZE-1:0] din, dout;
  mem_state_e            st;

  logic                  r1, w1, ready1;
  logic [ADDR_W-1:0]     a1;
  logic [BLOCK_SIZE-1:0] d1, dout1;
  mem_state_e            st1;

`ifdef MEM_STATS_EN
  logic [31:0] rdc, wrc, rdc1, wrc1;
`endif

  main_memory #(.MEM_LATENCY(4), .DEPTH_BLOCKS(1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .read_en_mem    (read_en),
    .write_en_mem   (write_en),
    .addr_mem       (addr),
    .dirty_block_in (din),
    .data_out_mem   (dout),
    .ready_mem      (ready),
`ifdef MEM_STATS_EN
    .rd_count       (rdc),
    .wr_count       (wrc),
`endif
    .state_dbg      (st)
  );

  main_memory #(.MEM_LATENCY(1), .DEPTH_BLOCKS(1024)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .read_en_mem    (r1),
    .write_en_mem   (w1),
    .addr_mem       (a1),
    .dirty_block_in (d1),
    .data_out_mem   (dout1),
    .ready_mem      (ready1),
`ifdef MEM_STATS_EN
    .rd_count       (rdc1),
    .wr_count       (wrc1),
`endif
    .state_dbg      (st1)
  );

  task automatic chk(input string tag, input logic [BLOCK_SIZE-1:0] obs,
                     input logic [BLOCK_SIZE-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called #1 after a rising edge with the DUT in IDLE
  task automatic req(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                     input logic [BLOCK_SIZE-1:0] d, input bit scramble, output int lat);
    write_en = wr;
    read_en  = rd;
    addr     = a;
    din      = d;
    @(posedge clk); #1;
    lat = 1;
    if (scramble) begin
      addr = ~a;
      din  = ~d;
    end
    while (ready !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $error("FAIL timeout: ready_mem never pulsed within %0d cycles", lat);
    end
  endtask

  task automatic drop(input string tag);
    write_en = 1'b0;
    read_en  = 1'b0;
    @(posedge clk); #1;
    chk(tag, ready, 1'b0);
  endtask

  logic [BLOCK_SIZE-1:0] pat;
  int lat, gap, seen;
  bit                    op_wr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [ADDR_W-1:0]     op_a  [5] = '{30'h3, 30'h4, 30'h3, 30'h4, 30'h3};
  logic [BLOCK_SIZE-1:0] op_d  [5] = '{128'hAAAA, 128'hBBBB, 128'h0, 128'h0, 128'h0};
  logic [BLOCK_SIZE-1:0] op_e  [5] = '{128'h0, 128'h0, 128'hAAAA, 128'hBBBB, 128'hAAAA};

  initial begin
    read_en = 0; write_en = 0; addr = '0; din = '0;
    r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    pat = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_dout", dout, 128'h0);
    chk("rst_state", st, IDLE);
    chk("rst_ready1", ready1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    req(1, 0, 30'h5, {4{32'hA5A5_A5A5}}, 0, lat);
    chk("wr5_lat", lat, 4);
    drop("wr5_low");
    req(0, 1, 30'h5, '0, 0, lat);
    chk("rd5_lat", lat, 4);
    chk("rd5_data", dout, {4{32'hA5A5_A5A5}});
    drop("rd5_low");
    chk("rd5_hold", dout, {4{32'hA5A5_A5A5}});

    req(1, 0, 30'h12, pat, 0, lat);
    chk("wr12_lat", lat, 4);
    chk("wr12_dout_held", dout, {4{32'hA5A5_A5A5}});
    drop("wr12_low");
    req(0, 1, 30'h12, '0, 0, lat);
    chk("rd12_data", dout, pat);
    drop("rd12_low");

    req(1, 1, 30'h7, 128'h1, 0, lat);
    chk("both_wr_lat", lat, 4);
    write_en = 1'b0;
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (ready !== 1'b1 && gap < 50);
    chk("both_gap", gap, 5);
    chk("both_rd_data", dout, 128'h1);
    drop("both_low");

    req(1, 0, 30'h400, 128'hF, 0, lat);
    drop("alias_wr_low");
    req(0, 1, 30'h0, '0, 0, lat);
    chk("alias_data", dout, 128'hF);
    drop("alias_rd_low");

    req(1, 0, 30'h20, 128'hDEAD_BEEF, 1, lat);
    chk("scr_lat", lat, 4);
    drop("scr_wr_low");
    req(0, 1, 30'h20, '0, 0, lat);
    chk("scr_data", dout, 128'hDEAD_BEEF);
    drop("scr_rd_low");

    req(1, 0, 30'h9, 128'h0, 0, lat);
    drop("wr9_low");
    write_en = 1'b1; addr = 30'h9; din = 128'hBAD0_BAD0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", ready, 1'b0);
    chk("abort_dout", dout, 128'h0);
    chk("abort_state", st, IDLE);
    write_en = 1'b0;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready === 1'b1) seen++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready === 1'b1) seen++;
    end
    chk("abort_no_pulse", seen, 0);
    req(0, 1, 30'h9, '0, 0, lat);
    chk("abort_rd9_lat", lat, 4);
    chk("abort_rd9_data", dout, 128'h0);
    drop("abort_rd9_low");

    w1 = op_wr[0]; r1 = !op_wr[0]; a1 = op_a[0]; d1 = op_d[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("l1_ready", ready1, 1'b1);
      if (!op_wr[i]) chk("l1_data", dout1, op_e[i]);
      if (i < 4) begin
        w1 = op_wr[i+1]; r1 = !op_wr[i+1]; a1 = op_a[i+1]; d1 = op_d[i+1];
      end else begin
        w1 = 1'b0; r1 = 1'b0;
      end
      @(posedge clk); #1;
      chk("l1_idle", ready1, 1'b0);
    end
`ifdef MEM_STATS_EN
    chk("l1_rd_count", rdc1, 32'd3);
    chk("l1_wr_count", wrc1, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
- Block-granular backing-store responder on the far end of the cache's memory interface.
- Accepts refill reads and dirty write-backs from cache_controller/cache_memory.
- Answers each request after a programmable latency with a one-cycle ready_mem pulse, returning one full cache block on reads.
- Instantiated beside the cache in top; also the bench's memory model.

Parameters:
- MEM_LATENCY, 4, cycles from request acceptance to ready_mem; legal range 1..255
- DEPTH_BLOCKS, 1024, number of BLOCK_SIZE-bit blocks stored; power of two
- ADDR_W, 30, block address width (24-bit tag + 6-bit index)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- read_en_mem  input  1  refill request; level, held until ready_mem
- write_en_mem  input  1  write-back request; level, held until ready_mem
- addr_mem  input  ADDR_W  block address {tag,index}; held with request
- dirty_block_in  input  `BLOCK_SIZE  write-back block data; held with request
- data_out_mem  output  `BLOCK_SIZE  refill block data
- ready_mem  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high): state=IDLE, ready_mem=0, data_out_mem=0, latency counter=0. Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If write_en_mem or read_en_mem is high, latch op, addr_mem, dirty_block_in; load counter with MEM_LATENCY-1; go to BUSY.
  - If MEM_LATENCY==1, go directly to RESP.
- BUSY: decrement counter each cycle; at 0 go to RESP.
- RESP (exactly one cycle): ready_mem=1.
  - Write: the array entry is updated at the end of this cycle.
  - Read: data_out_mem is driven with the stored block this cycle. data_out_mem holds that value until the next read response.
  - Next state is always IDLE.
- Latency: request sampled at edge N; ready_mem high during cycle N+MEM_LATENCY.
- Enables are ignored in BUSY and RESP. An enable still high in the cycle after RESP is treated as a new request, one cycle after return to IDLE. Requester must drop the enable in the cycle after seeing ready_mem.
- Both enables high in IDLE: write is accepted first. Read is accepted on its own only if still asserted after that write completes. This makes write-back-then-refill ordering safe.
- Array index = addr_mem[log2(DEPTH_BLOCKS)-1:0]; upper bits ignored, so addresses alias (wrap) modulo DEPTH_BLOCKS.
- Read-after-write to the same block returns the newly written data.
- Reset asserted mid-transaction:
  - Abort; no array write commits; no ready_mem pulse.
  - Outputs return to reset values immediately.
- Requester changing addr/data mid-transaction has no effect, because values are latched at acceptance.

Optional Feature:
- Macro MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0]. Each increments on the RESP cycle of a read or write respectively.
  - Both cleared by rst; both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cache_pkg (shared with the cache): BLOCK_SIZE, WORD_SIZE, ADDR_W, and the mem_state_e enum {IDLE, BUSY, RESP}.
- One sub-module, mem_array:
  - Synchronous single-port DEPTH_BLOCKS x BLOCK_SIZE storage: we, idx, wdata, rdata.
  - Registered read.
  - main_memory keeps the FSM, counter and latches.

Test Plan:
- Reset then read addr 0x0000_0005 (array preloaded 128'hA5A5...) -> ready_mem high exactly 4 cycles after accept; data_out_mem=128'hA5A5...; ready_mem low the next cycle.
- Write addr 0x12 with 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, then read 0x12 -> second ready_mem returns the identical block.
- Both enables high at addr 0x7, write data 128'h1, requester drops write after its ready_mem and keeps read -> write completes first; read then returns 128'h1; two ready_mem pulses 5 cycles apart (4 latency + 1 idle).
- Write addr 0x400 (aliases 0x000 at DEPTH 1024) with 128'hF, read 0x000 -> returns 128'hF.
- Assert rst in cycle 2 of a write to 0x9 (old value 128'h0) -> no ready_mem; later read of 0x9 returns 128'h0.
- MEM_LATENCY=1 with MEM_STATS_EN: 3 reads and 2 writes back-to-back -> each ready_mem 1 cycle after accept; rd_count=3, wr_count=2.
